// File: rtl/kvs_arb_pkg.sv
// Shared types, constants and the round-robin selection function for the
// KVS port arbiter.
package kvs_arb_pkg;

  localparam int KVS_DATA_WIDTH = 512;
  localparam int KVS_NUM_PORTS  = 4;
  localparam int KVS_MAX_PORTS  = 8;

  typedef logic [$clog2(KVS_NUM_PORTS)-1:0] port_idx_t;

  // First set bit of valid scanning upward from last+1, wrapping at num_ports.
  // Returns last unchanged when nothing is valid.
  function automatic logic [2:0] rr_next(
    input logic [KVS_MAX_PORTS-1:0] valid,
    input logic [2:0]               last,
    input int unsigned              num_ports
  );
    logic [2:0] cand;
    logic       found;
    rr_next = last;
    found   = 1'b0;
    for (int unsigned k = 1; k <= KVS_MAX_PORTS; k++) begin
      cand = 3'((32'(last) + k) % num_ports);
      if (k <= num_ports && !found && valid[cand]) begin
        rr_next = cand;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/kvs_tag_fifo.sv
// Small synchronous FIFO holding the source port of every issued request;
// the head entry is visible on dout while the FIFO is not empty.
module kvs_tag_fifo
  import kvs_arb_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = AW + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    dout     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/kvs_port_arbiter.sv
// Round-robin sharing of one in-order KVS engine between NUM_PORTS requesters,
// with a registered request stage and tag-FIFO based response routing.
module kvs_port_arbiter
  import kvs_arb_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int DATA_WIDTH      = KVS_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = 16,
  localparam int IDX_W          = $clog2(NUM_PORTS),
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [NUM_PORTS-1:0]          req_tvalid,
  output logic [NUM_PORTS-1:0]          req_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_tdata,
  output logic                          eng_req_tvalid,
  input  logic                          eng_req_tready,
  output logic [DATA_WIDTH-1:0]         eng_req_tdata,
  output logic [IDX_W-1:0]              eng_req_tid,
  input  logic                          eng_resp_tvalid,
  output logic                          eng_resp_tready,
  input  logic [DATA_WIDTH-1:0]         eng_resp_tdata,
  output logic [NUM_PORTS-1:0]          resp_tvalid,
  input  logic [NUM_PORTS-1:0]          resp_tready,
  output logic [DATA_WIDTH-1:0]         resp_tdata,
  output logic [CNT_W-1:0]              outstanding,
  output logic                          err_orphan
);

  logic [DATA_WIDTH-1:0]    req_words [NUM_PORTS];
  logic                     eng_vld_q, eng_vld_d;
  logic [DATA_WIDTH-1:0]    eng_data_q, eng_data_d;
  logic [IDX_W-1:0]         eng_tid_q, eng_tid_d;
  logic [IDX_W-1:0]         last_grant_q, last_grant_d;
  logic [CNT_W-1:0]         outstanding_q, outstanding_d;
  logic                     err_orphan_q, err_orphan_d;
  logic [KVS_MAX_PORTS-1:0] valid_ext;
  logic [IDX_W-1:0]         grant_idx;
  logic                     can_load, grant, eng_hs;
  logic                     tag_pop, tag_empty, tag_full;
  logic [IDX_W-1:0]         tag_head;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_req_words
    assign req_words[gi] = req_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    valid_ext                  = '0;
    valid_ext[NUM_PORTS-1:0]   = req_tvalid;
    grant_idx = IDX_W'(rr_next(valid_ext, 3'(last_grant_q), NUM_PORTS));
    eng_hs    = eng_vld_q && eng_req_tready;
    can_load  = !eng_vld_q || eng_req_tready;
    // Held requests count toward the limit, so the tag FIFO cannot fill first.
    grant     = can_load && !tag_full && (outstanding_q < CNT_W'(MAX_OUTSTANDING))
                && (|req_tvalid);

    req_tready = '0;
    if (grant) req_tready[grant_idx] = 1'b1;

    // With no tag pending, any response is an orphan: accept and drop it.
    resp_tvalid     = '0;
    eng_resp_tready = eng_resp_tvalid;
    if (!tag_empty) begin
      resp_tvalid[tag_head] = eng_resp_tvalid;
      eng_resp_tready       = resp_tready[tag_head];
    end
    tag_pop = eng_resp_tvalid && eng_resp_tready && !tag_empty;

    eng_vld_d    = eng_vld_q;
    eng_data_d   = eng_data_q;
    eng_tid_d    = eng_tid_q;
    last_grant_d = last_grant_q;
    if (grant) begin
      eng_vld_d    = 1'b1;
      eng_data_d   = req_words[grant_idx];
      eng_tid_d    = grant_idx;
      last_grant_d = grant_idx;
    end else if (eng_hs) begin
      eng_vld_d = 1'b0;
    end

    outstanding_d = outstanding_q;
    if (grant && !tag_pop)      outstanding_d = outstanding_q + CNT_W'(1);
    else if (!grant && tag_pop) outstanding_d = outstanding_q - CNT_W'(1);

    err_orphan_d = err_orphan_q || (eng_resp_tvalid && tag_empty);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      eng_vld_q     <= 1'b0;
      last_grant_q  <= IDX_W'(NUM_PORTS - 1);
      outstanding_q <= '0;
      err_orphan_q  <= 1'b0;
    end else begin
      eng_vld_q     <= eng_vld_d;
      last_grant_q  <= last_grant_d;
      outstanding_q <= outstanding_d;
      err_orphan_q  <= err_orphan_d;
    end
  end

  always_ff @(posedge aclk) begin
    eng_data_q <= eng_data_d;
    eng_tid_q  <= eng_tid_d;
  end

  kvs_tag_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk   (aclk),
    .srst  (areset),
    .push  (eng_hs),
    .pop   (tag_pop),
    .din   (eng_tid_q),
    .dout  (tag_head),
    .empty (tag_empty),
    .full  (tag_full)
  );

  assign eng_req_tvalid = eng_vld_q;
  assign eng_req_tdata  = eng_data_q;
  assign eng_req_tid    = eng_tid_q;
  assign resp_tdata     = eng_resp_tdata;
  assign outstanding    = outstanding_q;
  assign err_orphan     = err_orphan_q;

endmodule

// File: tb/tb_kvs_port_arbiter.sv
// Directed scenarios plus randomized traffic for kvs_port_arbiter, checked
// every cycle against a queue-based behavioural model.
module tb_kvs_port_arbiter;

  localparam int NP   = 4;
  localparam int DW   = 512;
  localparam int MAXO = 16;

  logic              clk = 1'b0;
  logic              areset;
  logic [NP-1:0]     req_tvalid;
  logic [NP-1:0]     req_tready;
  logic [NP*DW-1:0]  req_tdata;
  logic              eng_req_tvalid;
  logic              eng_req_tready;
  logic [DW-1:0]     eng_req_tdata;
  logic [1:0]        eng_req_tid;
  logic              eng_resp_tvalid;
  logic              eng_resp_tready;
  logic [DW-1:0]     eng_resp_tdata;
  logic [NP-1:0]     resp_tvalid;
  logic [NP-1:0]     resp_tready;
  logic [DW-1:0]     resp_tdata;
  logic [4:0]        outstanding;
  logic              err_orphan;

  always #5 clk = ~clk;

  kvs_port_arbiter #(
    .NUM_PORTS       (NP),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .aclk            (clk),
    .areset          (areset),
    .req_tvalid      (req_tvalid),
    .req_tready      (req_tready),
    .req_tdata       (req_tdata),
    .eng_req_tvalid  (eng_req_tvalid),
    .eng_req_tready  (eng_req_tready),
    .eng_req_tdata   (eng_req_tdata),
    .eng_req_tid     (eng_req_tid),
    .eng_resp_tvalid (eng_resp_tvalid),
    .eng_resp_tready (eng_resp_tready),
    .eng_resp_tdata  (eng_resp_tdata),
    .resp_tvalid     (resp_tvalid),
    .resp_tready     (resp_tready),
    .resp_tdata      (resp_tdata),
    .outstanding     (outstanding),
    .err_orphan      (err_orphan)
  );

  int n_checks = 0;
  int n_errors = 0;
  int dut_grants = 0;
  bit checks_en = 0;

  // Reference model state: pending engine word, in-order tag queue, counters.
  bit          m_out_valid;
  int          m_out_tid;
  logic [DW-1:0] m_out_data;
  int          m_tags[$];
  int          m_last;
  int          m_outst;
  bit          m_orphan;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_clear();
    m_out_valid = 0;
    m_out_tid   = 0;
    m_out_data  = '0;
    m_tags.delete();
    m_last      = NP - 1;
    m_outst     = 0;
    m_orphan    = 0;
  endtask

  // Evaluate expectations for the current inputs, compare, then advance the model.
  task automatic model_eval();
    int g, head;
    bit can_load, do_pop, hs;
    logic [NP-1:0] exp_rdy, exp_rv;
    bit exp_ert;
    can_load = !m_out_valid || eng_req_tready;
    g = -1;
    if (can_load && m_outst < MAXO)
      for (int k = 1; k <= NP; k++) begin
        int p;
        p = (m_last + k) % NP;
        if (req_tvalid[p] && g < 0) g = p;
      end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_rv = '0;
    head = (m_tags.size() > 0) ? m_tags[0] : -1;
    if (head >= 0) begin
      exp_rv[head] = eng_resp_tvalid;
      exp_ert      = resp_tready[head];
    end else begin
      exp_ert = eng_resp_tvalid;
    end
    if (checks_en) begin
      check("req_tready", req_tready, exp_rdy);
      check("eng_req_tvalid", eng_req_tvalid, m_out_valid);
      if (m_out_valid) begin
        check("eng_req_tid", eng_req_tid, m_out_tid[1:0]);
        check("eng_req_tdata", eng_req_tdata, m_out_data);
      end
      check("resp_tvalid", resp_tvalid, exp_rv);
      if (head >= 0 || eng_resp_tvalid) check("eng_resp_tready", eng_resp_tready, exp_ert);
      if (exp_rv != 0) check("resp_tdata", resp_tdata, eng_resp_tdata);
      check("outstanding", outstanding, m_outst[4:0]);
      check("err_orphan", err_orphan, m_orphan);
    end
    if (req_tready != 0) dut_grants++;

    if (areset) begin
      model_clear();
    end else begin
      hs     = m_out_valid && eng_req_tready;
      do_pop = (head >= 0) && eng_resp_tvalid && resp_tready[head];
      if (do_pop) begin
        void'(m_tags.pop_front());
        $display("resp    port=%0d data=%08h", head, eng_resp_tdata[31:0]);
      end
      if (head < 0 && eng_resp_tvalid) begin
        m_orphan = 1;
        $display("orphan  data=%08h dropped", eng_resp_tdata[31:0]);
      end
      if (hs) begin
        m_tags.push_back(m_out_tid);
        $display("eng_req tid=%0d data=%08h", m_out_tid, m_out_data[31:0]);
      end
      if (g >= 0) begin
        m_out_valid = 1;
        m_out_tid   = g;
        m_out_data  = req_tdata[g*DW +: DW];
        m_last      = g;
      end else if (hs) begin
        m_out_valid = 0;
      end
      m_outst = m_outst + ((g >= 0) ? 1 : 0) - (do_pop ? 1 : 0);
    end
  endtask

  // Inputs are set at the falling edge; this evaluates, then advances one clock.
  task automatic run_cycle();
    #1;
    model_eval();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    areset          = 0;
    req_tvalid      = '0;
    eng_req_tready  = 1;
    eng_resp_tvalid = 0;
    resp_tready     = '1;
  endtask

  task automatic fill_req_data();
    for (int p = 0; p < NP; p++) req_tdata[p*DW +: DW] = rand_word();
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      set_idle();
      eng_resp_tvalid = (m_tags.size() > 0);
      eng_resp_tdata  = rand_word();
      if (m_tags.size() == 0 && !m_out_valid) break;
      run_cycle();
    end
    #1;
    check("drain_outstanding", outstanding, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    areset         = 1;
    req_tdata      = '0;
    eng_resp_tdata = '0;
    model_clear();
    @(negedge clk);
    run_cycle();
    checks_en = 1;
    run_cycle();
    areset = 0;
    run_cycle();

    // Single request from port 2, response routed back to port 2.
    req_tdata[2*DW +: DW] = DW'(8'hAB);
    req_tvalid = 4'b0100;
    run_cycle();
    req_tvalid = '0;
    run_cycle();
    check("single_tid", eng_req_tid, 2);
    run_cycle();
    eng_resp_tvalid = 1;
    eng_resp_tdata  = DW'(8'hCD);
    #1;
    check("single_resp", resp_tvalid, 4'b0100);
    run_cycle();
    drain();

    // Round robin with every port valid.
    for (int i = 0; i < 8; i++) begin
      fill_req_data();
      req_tvalid = '1;
      run_cycle();
    end
    drain();

    // Engine stall for 5 cycles with all ports requesting.
    req_tvalid = '1;
    fill_req_data();
    run_cycle();
    eng_req_tready = 0;
    for (int i = 0; i < 5; i++) begin
      fill_req_data();
      run_cycle();
    end
    eng_req_tready = 1;
    for (int i = 0; i < 3; i++) run_cycle();
    drain();

    // Outstanding limit: no responses, then a single response frees one slot.
    dut_grants = 0;
    req_tvalid = '1;
    for (int i = 0; i < 20; i++) begin
      fill_req_data();
      run_cycle();
    end
    check("limit_grants", dut_grants, MAXO);
    dut_grants      = 0;
    eng_resp_tvalid = 1;
    run_cycle();
    eng_resp_tvalid = 0;
    for (int i = 0; i < 4; i++) run_cycle();
    check("limit_release", dut_grants, 1);
    drain();

    // Response backpressure: tags 1 then 3, port 1 stalls for 4 cycles.
    req_tvalid = 4'b0010;
    run_cycle();
    req_tvalid = 4'b1000;
    run_cycle();
    req_tvalid = '0;
    run_cycle();
    run_cycle();
    eng_resp_tvalid = 1;
    resp_tready     = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      eng_resp_tdata = rand_word();
      run_cycle();
    end
    resp_tready = '1;
    drain();

    // Orphan response, then reset clears it and port 0 wins first.
    eng_resp_tvalid = 1;
    eng_resp_tdata  = rand_word();
    run_cycle();
    eng_resp_tvalid = 0;
    run_cycle();
    check("orphan_set", err_orphan, 1);
    areset = 1;
    run_cycle();
    areset     = 0;
    req_tvalid = '1;
    fill_req_data();
    #1;
    check("post_reset_grant", req_tready, 4'b0001);
    run_cycle();
    drain();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      areset          = ($urandom_range(0, 199) == 0);
      req_tvalid      = NP'($urandom);
      fill_req_data();
      eng_req_tready  = ($urandom_range(0, 3) != 0);
      eng_resp_tvalid = ($urandom_range(0, 2) == 0);
      eng_resp_tdata  = rand_word();
      for (int p = 0; p < NP; p++) resp_tready[p] = ($urandom_range(0, 4) != 0);
      run_cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
